// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC sequencer family.
// Phase is 11-bit two's complement: a full circle is 2048 LSB and 0x400 is +/-pi.
package cordic_pkg;

    localparam int RE_W   = 12;
    localparam int PHI_W  = 11;
    localparam int ITER_W = 4;

    localparam logic signed [PHI_W-1:0] PHI_PI = 11'h400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [RE_W-1:0]  re;
        logic signed [RE_W-1:0]  im;
        logic signed [PHI_W-1:0] phi;
    } operand_t;

    // The most negative value has no positive counterpart, so it clamps to the max.
    function automatic logic signed [RE_W-1:0] neg_sat(input logic signed [RE_W-1:0] x);
        if (x == {1'b1, {(RE_W-1){1'b0}}})
            return {1'b0, {(RE_W-1){1'b1}}};
        return -x;
    endfunction

endpackage

// File: rtl/cordic_prerot.sv
// Combinational quadrant fold: samples in the left half-plane are rotated by pi
// so the iterations only ever have to cover +/-pi/2.
module cordic_prerot
    import cordic_pkg::*;
(
    input  logic signed [RE_W-1:0] in_re,
    input  logic signed [RE_W-1:0] in_im,
    output operand_t               op
);

    always_comb begin
        op = '0;
        if (in_re[RE_W-1]) begin
            op.re  = neg_sat(in_re);
            op.im  = neg_sat(in_im);
            op.phi = PHI_PI;
        end else begin
            op.re  = in_re;
            op.im  = in_im;
            op.phi = '0;
        end
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC vectoring sequencer: folds one sample, drives a shared external
// iteration stage N_ITER times with feedback, then presents magnitude and phase.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int N_ITER   = 12,
    parameter int ITER_LAT = 0
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [RE_W-1:0]  in_re,
    input  logic signed [RE_W-1:0]  in_im,
    output logic signed [RE_W-1:0]  it_re_o,
    output logic signed [RE_W-1:0]  it_im_o,
    output logic signed [PHI_W-1:0] it_phi_o,
    output logic [ITER_W-1:0]       it_iter_o,
    input  logic signed [RE_W-1:0]  it_re_i,
    input  logic signed [RE_W-1:0]  it_im_i,
    input  logic signed [PHI_W-1:0] it_phi_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [RE_W-1:0]  out_amp,
    output logic signed [PHI_W-1:0] out_phi,
    output logic [1:0]              dbg_state
);

    generate
        if (N_ITER < 1 || N_ITER > 16) begin : g_bad_n_iter
            $error("cordic_iter_ctrl: N_ITER must be in 1..16");
        end
        if (ITER_LAT != 0 && ITER_LAT != 1) begin : g_bad_iter_lat
            $error("cordic_iter_ctrl: ITER_LAT must be 0 or 1");
        end
    endgenerate

    state_t            state, state_nx;
    operand_t          op, pre;
    logic [ITER_W-1:0] iter;
    logic              lat_cnt;
    logic              last_cyc, capture, done, accept, out_hs;

    cordic_prerot u_prerot (
        .in_re (in_re),
        .in_im (in_im),
        .op    (pre)
    );

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; valid and its payload are held stable until that edge, and ready never
    // depends combinationally on valid.
    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // lat_cnt marks the second cycle of an iteration when the stage is registered.
    assign last_cyc = (ITER_LAT == 0) ? 1'b1 : lat_cnt;
    assign capture  = (state == RUN) && last_cyc;
    assign done     = capture && (iter == ITER_W'(N_ITER - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (done)   state_nx = OUT;
            OUT:     if (out_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op        <= '0;
            iter      <= '0;
            lat_cnt   <= 1'b0;
            out_valid <= 1'b0;
            out_amp   <= '0;
            out_phi   <= '0;
        end else begin
            lat_cnt <= (state == RUN) && !last_cyc;
            // The final result goes to the output registers only, so the stage
            // operands keep showing the last iteration while the result waits.
            if (accept) begin
                op   <= pre;
                iter <= '0;
            end else if (capture && !done) begin
                op   <= '{re: it_re_i, im: it_im_i, phi: it_phi_i};
                iter <= iter + 1'b1;
            end
            if (done) begin
                out_valid <= 1'b1;
                out_amp   <= it_re_i;
                out_phi   <= it_phi_i;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign it_re_o   = op.re;
    assign it_im_o   = op.im;
    assign it_phi_o  = op.phi;
    assign it_iter_o = iter;
    assign dbg_state = state;

endmodule
